// File: rtl/timer_pkg.sv
// Shared timer constants: register map, CTRL bit positions, mode codes and FSM encoding.
// Auto-reload (Mode 1) exists only when TIMER_AUTOLOAD_EN is defined.
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_AUTOLOAD = 2'd1;

`ifdef TIMER_AUTOLOAD_EN
    localparam bit AUTOLOAD_EN = 1'b1;
`else
    localparam bit AUTOLOAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Modes 0, 2 and 3 are one-shot; Mode 1 reloads only when the feature is built in.
    function automatic logic is_autoload(input logic [1:0] mode);
        return AUTOLOAD_EN && (mode == MODE_AUTOLOAD);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator: one-cycle tick every DIV enabled cycles, restarted from zero on LOAD.
module timer_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (restart) begin
            pre_d  = '0;
            tick_d = 1'b0;
        end else if (en) begin
            tick_d = (pre_q == LAST);
            pre_d  = (pre_q == LAST) ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    // The divided tick is registered to keep the compare off the COUNT path;
    // with DIV=1 every enabled cycle is a tick.
    assign tick = (DIV == 1) ? en : (tick_q & en);

endmodule

// File: rtl/timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with maskable interrupt.
// Optional auto-reload Mode 1 is enabled by defining TIMER_AUTOLOAD_EN.
module timer
    import timer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        Wen,
    input  logic [31:0] Din,
    output logic [31:0] DOut,
    output logic        IRQ
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       preset_q, preset_d;
    logic [31:0]       count_q, count_d;
    state_e            state_q, state_d;
    logic              irq_flag_q, irq_flag_d;

    logic ctrl_wr;
    logic preset_wr;
    logic autoload;
    logic tick;

    assign ctrl_wr   = Wen && (Addr == ADDR_CTRL);
    assign preset_wr = Wen && (Addr == ADDR_PRESET);
    assign autoload  = is_autoload(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);

    timer_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (reset),
        .restart (state_q == ST_LOAD),
        .en      (state_q == ST_CNT),
        .tick    (tick)
    );

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        state_d    = state_q;
        irq_flag_d = irq_flag_q;

        if (preset_wr) begin
            preset_d = Din;
        end

        // A CTRL write overrides whatever the counter was about to do this edge.
        if (ctrl_wr) begin
            ctrl_d     = Din[CTRL_W-1:0];
            irq_flag_d = 1'b0;
            state_d    = Din[CTRL_EN_BIT] ? ST_LOAD : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_LOAD: begin
                    count_d = preset_q;
                    if (preset_q == 32'd0) begin
                        irq_flag_d = 1'b1;
                        state_d    = ST_INT;
                    end else begin
                        state_d = ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (tick) begin
                        if (count_q <= 32'd1) begin
                            count_d    = 32'd0;
                            irq_flag_d = 1'b1;
                            state_d    = ST_INT;
                        end else begin
                            count_d = count_q - 32'd1;
                        end
                    end
                end
                ST_INT: begin
                    if (autoload) begin
                        irq_flag_d = 1'b0;
                        state_d    = ST_LOAD;
                    end
                end
            endcase

            // One-shot expiry disarms the timer so software sees Enable drop.
            if (state_d == ST_INT && !autoload) begin
                ctrl_d[CTRL_EN_BIT] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            irq_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (Addr)
            ADDR_CTRL:   DOut = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: DOut = preset_q;
            ADDR_COUNT:  DOut = count_q;
            ADDR_RSVD:   DOut = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q[CTRL_IM_BIT];

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have parameter DIV, default 1: clk cycles per count tick, legal range 1..256.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Addr, input, 2 bits: register select. 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 SHALL have port Wen, input, 1 bit: write enable, sampled on the rising edge.
REQ-006 SHALL have port Din, input, 32 bits: write data.
REQ-007 SHALL have port DOut, output, 32 bits: combinational read data for Addr.
REQ-008 SHALL have port IRQ, output, 1 bit: interrupt request, wired to one CP0 HWInt bit.

Function
REQ-009 SHALL define CTRL[0]=Enable, CTRL[2:1]=Mode, CTRL[3]=IM; CTRL[31:4] read as 0.
- Mode 0: one-shot. Mode 1: auto-reload. Modes 2/3 behave as mode 0.
REQ-010 SHALL ignore writes to COUNT and reserved Addr 3; reads of Addr 3 return 0.
REQ-011 SHALL implement states IDLE, LOAD, CNT, INT; IRQ SHALL equal irq_flag AND CTRL.IM, both registered.
REQ-012 SHALL, on any CTRL write, clear irq_flag and enter LOAD if Din[0]=1, else IDLE; COUNT holds its value when entering IDLE.
REQ-013 SHALL, in LOAD, set COUNT to PRESET, reset the prescaler, and go to CNT on the next edge; if PRESET=0, go directly to INT with irq_flag set.
REQ-014 SHALL, in CNT, decrement COUNT by 1 on each tick; a tick occurring at COUNT=1 SHALL set COUNT=0, set irq_flag, and enter INT.
REQ-015 SHALL, with DIV=1 and PRESET=N>=1, assert irq_flag exactly N+1 edges after the edge that wrote CTRL with Enable=1.
REQ-016 SHALL, in INT with Mode 0, clear CTRL.Enable by hardware and hold irq_flag and INT until a CTRL write or reset.
REQ-017 SHALL, in INT with Mode 1, hold irq_flag for exactly one cycle, then clear it and go to LOAD.
REQ-018 SHALL apply a PRESET write during CNT only at the next LOAD.
REQ-019 SHALL give a same-edge CTRL write priority over the terminal-count transition; irq_flag stays 0.
REQ-020 SHALL use 32-bit COUNT arithmetic with no wrap below 0; the prescaler SHALL wrap from DIV-1 to 0.

Reset
REQ-021 SHALL, while reset=0 and independent of clk, force CTRL=0, PRESET=0, COUNT=0, prescaler=0, state=IDLE, irq_flag=0.
REQ-022 SHALL therefore drive IRQ=0 and DOut=0 for every Addr during reset.
REQ-023 SHALL abandon any count in progress when reset is asserted; no IRQ results after release.

Configuration
REQ-024 SHALL honour macro TIMER_AUTOLOAD_EN.
- Defined: Mode 1 behaves as REQ-017.
- Undefined: Mode 1 behaves exactly as Mode 0, and CTRL[2:1] reads back as written.

Structure
REQ-025 SHALL place the following constants in the shared macro header used by the CPU units: register addresses, CTRL bit positions, mode codes, state encodings.
REQ-026 SHALL contain one sub-module, timer_prescaler, which generates the one-cycle tick from DIV and restarts on LOAD.

Verification
REQ-027 Reset: drive reset=0 mid-count (COUNT=5) -> COUNT=0, IRQ=0, DOut=0 for Addr 0..2, without a clk edge.
REQ-028 One-shot:
- Stimulus: DIV=1, PRESET=3, CTRL=32'h9.
- Response: COUNT reads 3,2,1,0; IRQ rises 4 edges after the CTRL write; CTRL reads 32'h8; IRQ holds until CTRL=0 is written.
REQ-029 Auto-reload:
- Stimulus: TIMER_AUTOLOAD_EN defined, PRESET=2, CTRL=32'hB.
- Response: IRQ is a one-cycle pulse every 4 cycles; at least 3 pulses are observed.
REQ-030 Mask and PRESET=0:
- Stimulus: CTRL=32'h1, PRESET=0.
- Response: IRQ stays 0, the internal flag is set, and COUNT=0.
REQ-031 Prescale: DIV=4, PRESET=2, CTRL=32'h9 -> IRQ asserts 10 edges after the write.
REQ-032 Collision: a CTRL=32'h0 write lands on the terminal-count edge -> IRQ stays 0, state=IDLE, COUNT=1.
